bbs32_core: RTL and testbench

- Blum Blum Shub generator engine behind the bbs32 register file.
- Consumes the register-to-logic struct (p, q, seed, start, keep_m, use_xnext).
- Computes the modulus m = p*q, reduces and squares the seed, then iterates x(i+1) = x(i)^2 mod m. It collects the parity bit of 32 successive states into rand_word.
- Drives the logic-to-register struct, including the one-cycle update strobes for the m_valid and result_valid status bits.

---
 rtl/bbs32_reg_pkg.sv | 23 ++
 rtl/bbs32_modmul.sv | 39 +++
 rtl/bbs32_core.sv | 125 ++++++++++++
 tb/tb_bbs32_core.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/bbs32_reg_pkg.sv
// bbs32_reg_pkg: register-file structs, FSM states and sizing constants for the bbs32 generator.
package bbs32_reg_pkg;
  localparam int BBS32_SQ_ITER = 64;
  localparam int BBS32_WORD_BITS = 32;
  typedef enum logic [2:0] {IDLE, MUL, CHK, RED, SQ, DONE} bbs32_state_e;
  typedef struct packed {
    logic [31:0] p;
    logic [31:0] q;
    logic [31:0] seed;
    logic        start;
    logic        keep_m;
    logic        use_xnext;
  } bbs32_reg2hw_t;
  typedef struct packed {
    logic [31:0] m_lsb;
    logic [31:0] m_msb;
    logic [31:0] rand_word;
    logic        m_valid;
    logic        result_valid;
    logic        m_valid_upd;
    logic        result_valid_upd;
  } bbs32_hw2reg_t;
endpackage

// File: rtl/bbs32_modmul.sv
// bbs32_modmul: iterative (a*b) mod m, one bit of b per cycle MSB first; r is final in the done cycle.
module bbs32_modmul (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [63:0] m,
  input  logic [6:0]  nbits,
  input  logic        start,
  output logic [63:0] r,
  output logic        done
);
  logic [63:0] r_q, rr;
  logic [6:0] cnt_q, cnt, idx;
  logic busy_q, bit_b;
  logic [64:0] t0, t1, t2, t3;
  always_comb begin
    cnt = start ? 7'd0 : cnt_q;
    rr = start ? 64'd0 : r_q;
    idx = nbits - 7'd1 - cnt;
    bit_b = |(b & (64'd1 << idx));
    t0 = {rr, 1'b0};
    t1 = t0 >= {1'b0, m} ? t0 - {1'b0, m} : t0;
    t2 = bit_b ? t1 + {1'b0, a} : t1;
    t3 = t2 >= {1'b0, m} ? t2 - {1'b0, m} : t2;
    r = t3[63:0];
    done = (start || busy_q) && cnt == nbits - 7'd1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else if (start || busy_q) begin
      r_q <= r;
      cnt_q <= cnt + 7'd1;
      busy_q <= !done;
    end
endmodule

// File: rtl/bbs32_core.sv
// bbs32_core: Blum Blum Shub engine computing m=p*q and collecting parity bits of successive x^2 mod m.
module bbs32_core
  import bbs32_reg_pkg::*;
#(
  parameter int SqIter = BBS32_SQ_ITER,
  parameter int WordBits = BBS32_WORD_BITS
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  bbs32_reg2hw_t reg2hw_i,
  output bbs32_hw2reg_t hw2reg_o
);
  bbs32_state_e state, nxt;
  logic start_q, go, seed_sq, seed_sq_nx, mm_start, mm_start_nx, mm_done;
  logic [4:0] cnt, cnt_nx;
  logic [63:0] m, m_nx, x, x_nx, mm_r, mm_a, mm_b;
  logic [6:0] mm_n;
  logic [30:0] sr, sr_nx;
  logic [31:0] rw, rw_nx;
  logic mv, mv_nx, rv, rv_nx, mv_upd, mv_upd_nx, rv_upd, rv_upd_nx;
  bbs32_modmul u_modmul (
    .clk_i(clk_i), .rst_ni(rst_ni), .a(mm_a), .b(mm_b), .m(m),
    .nbits(mm_n), .start(mm_start), .r(mm_r), .done(mm_done)
  );
  always_comb begin
    go = state == IDLE && reg2hw_i.start && !start_q;
    nxt = state;
    m_nx = m;
    x_nx = x;
    sr_nx = sr;
    cnt_nx = cnt;
    seed_sq_nx = seed_sq;
    mm_start_nx = 1'b0;
    rw_nx = rw;
    mv_nx = mv;
    rv_nx = rv;
    mv_upd_nx = 1'b0;
    rv_upd_nx = 1'b0;
    case (state)
      IDLE: if (go) begin
        rv_upd_nx = 1'b1;
        rv_nx = 1'b0;
        if (!reg2hw_i.keep_m || !mv) begin
          nxt = MUL;
          m_nx = '0;
          cnt_nx = '0;
          mv_upd_nx = 1'b1;
          mv_nx = 1'b0;
        end else nxt = CHK;
      end
      MUL: begin
        m_nx = reg2hw_i.q[cnt] ? m + ({32'd0, reg2hw_i.p} << cnt) : m;
        cnt_nx = cnt + 5'd1;
        if (cnt == 5'(WordBits - 1)) nxt = CHK;
      end
      CHK: begin
        cnt_nx = '0;
        seed_sq_nx = !reg2hw_i.use_xnext;
        mm_start_nx = m >= 64'd2;
        nxt = m < 64'd2 ? DONE : reg2hw_i.use_xnext ? SQ : RED;
      end
      RED: if (mm_done) begin
        x_nx = mm_r;
        mm_start_nx = 1'b1;
        nxt = SQ;
      end
      SQ: if (mm_done) begin
        // the seed squaring only produces x0; bits come from the squarings after it
        x_nx = mm_r;
        seed_sq_nx = 1'b0;
        if (!seed_sq) begin
          sr_nx = {sr[29:0], mm_r[0]};
          cnt_nx = cnt + 5'd1;
        end
        if (!seed_sq && cnt == 5'(WordBits - 1)) nxt = DONE;
        else mm_start_nx = 1'b1;
      end
      default: nxt = IDLE;
    endcase
    if (nxt == CHK) begin
      mv_upd_nx = 1'b1;
      mv_nx = m_nx >= 64'd2;
    end
    if (nxt == DONE) begin
      rv_upd_nx = 1'b1;
      rv_nx = 1'b1;
      rw_nx = state == SQ ? {sr, mm_r[0]} : '0;
    end
    mm_a = state == RED ? 64'd1 : x;
    mm_b = state == RED ? {32'd0, reg2hw_i.seed} : x;
    mm_n = state == RED ? 7'(WordBits) : 7'(SqIter);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      start_q <= 1'b0;
      seed_sq <= 1'b0;
      mm_start <= 1'b0;
      cnt <= '0;
      m <= '0;
      x <= '0;
      sr <= '0;
      rw <= '0;
      mv <= 1'b0;
      rv <= 1'b0;
      mv_upd <= 1'b0;
      rv_upd <= 1'b0;
    end else begin
      state <= nxt;
      start_q <= reg2hw_i.start;
      seed_sq <= seed_sq_nx;
      mm_start <= mm_start_nx;
      cnt <= cnt_nx;
      m <= m_nx;
      x <= x_nx;
      sr <= sr_nx;
      rw <= rw_nx;
      mv <= mv_nx;
      rv <= rv_nx;
      mv_upd <= mv_upd_nx;
      rv_upd <= rv_upd_nx;
    end
  assign hw2reg_o = '{m_lsb: m[31:0], m_msb: m[63:32], rand_word: rw, m_valid: mv,
                      result_valid: rv, m_valid_upd: mv_upd, result_valid_upd: rv_upd};
endmodule

// File: tb/tb_bbs32_core.sv
// tb_bbs32_core: scoreboard bench; stimulus queues expected strobe events, a monitor pops and compares them.
module tb_bbs32_core;
  import bbs32_reg_pkg::*;
  typedef struct {
    int cyc;
    logic mvu, rvu, mv, rv, cm, cw;
    logic [63:0] m;
    logic [31:0] w;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bbs32_reg2hw_t r2h = '0;
  bbs32_hw2reg_t h2r;
  exp_t sb[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  bbs32_core dut (.clk_i(clk), .rst_ni(rst_n), .reg2hw_i(r2h), .hw2reg_o(h2r));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [63:0] sq(input logic [63:0] x, input logic [63:0] m);
    return 64'(({64'd0, x} * {64'd0, x}) % {64'd0, m});
  endfunction
  task automatic model(input logic [63:0] m, input logic [63:0] x_in, input logic fresh,
                       output logic [31:0] wo, output logic [63:0] xo);
    logic [63:0] x;
    x = fresh ? sq(x_in % m, m) : x_in;
    wo = '0;
    for (int i = 0; i < 32; i++) begin
      x = sq(x, m);
      wo = {wo[30:0], x[0]};
    end
    xo = x;
  endtask
  always @(negedge clk)
    if (h2r.m_valid_upd || h2r.result_valid_upd) begin
      if (sb.size() == 0)
        chk("unexpected_strobe", 64'({h2r.m_valid_upd, h2r.result_valid_upd}), 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("cycle", 64'(cyc), 64'(e.cyc));
        chk("strobes", 64'({h2r.m_valid_upd, h2r.result_valid_upd}), 64'({e.mvu, e.rvu}));
        chk("m_valid", 64'(h2r.m_valid), 64'(e.mv));
        chk("result_valid", 64'(h2r.result_valid), 64'(e.rv));
        if (e.cm) chk("m", {h2r.m_msb, h2r.m_lsb}, e.m);
        if (e.cw) chk("rand_word", 64'(h2r.rand_word), 64'(e.w));
      end
    end
  task automatic issue(input logic [31:0] p, input logic [31:0] q, input logic [31:0] seed,
                       input logic keep, input logic xn, input int lat, input logic mul,
                       input logic [31:0] wexp);
    logic [63:0] m;
    logic mv;
    exp_t e;
    m = {32'd0, p} * {32'd0, q};
    mv = m >= 64'd2;
    @(posedge clk);
    #1;
    r2h.p = p;
    r2h.q = q;
    r2h.seed = seed;
    r2h.keep_m = keep;
    r2h.use_xnext = xn;
    e = '{cyc: cyc + 1, mvu: 1'b1, rvu: 1'b1, mv: mul ? 1'b0 : mv, rv: 1'b0, cm: !mul, cw: 1'b0, m: m, w: '0};
    sb.push_back(e);
    if (mul) begin
      e = '{cyc: cyc + 33, mvu: 1'b1, rvu: 1'b0, mv: mv, rv: 1'b0, cm: 1'b1, cw: 1'b0, m: m, w: '0};
      sb.push_back(e);
    end
    e = '{cyc: cyc + lat, mvu: 1'b0, rvu: 1'b1, mv: mv, rv: 1'b1, cm: 1'b1, cw: 1'b1, m: m, w: wexp};
    sb.push_back(e);
    r2h.start = 1'b1;
    @(posedge clk);
    #1;
    r2h.start = 1'b0;
  endtask
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    repeat (5) @(posedge clk);
  endtask
  initial begin
    logic [31:0] w1, w;
    logic [63:0] x1, x2;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m", {h2r.m_msb, h2r.m_lsb}, 64'd0);
    chk("reset_word", 64'(h2r.rand_word), 64'd0);
    chk("reset_flags", 64'({h2r.m_valid, h2r.result_valid, h2r.m_valid_upd, h2r.result_valid_upd}), 64'd0);
    rst_n = 1'b1;
    model(64'd209, 64'd3, 1'b1, w1, x1);
    issue(32'd11, 32'd19, 32'd3, 1'b0, 1'b0, 2178, 1'b1, w1);
    wait_done(2300);
    model(64'd209, x1, 1'b0, w, x2);
    issue(32'd11, 32'd19, 32'd3, 1'b1, 1'b1, 2050, 1'b0, w);
    wait_done(2300);
    issue(32'd11, 32'd19, 32'd3, 1'b1, 1'b0, 2146, 1'b0, w1);
    wait_done(2300);
    issue(32'd11, 32'd19, 32'd3, 1'b0, 1'b1, 2082, 1'b1, w);
    wait_done(2300);
    // a second rising edge on start while squaring must not spawn another run
    issue(32'd3, 32'd5, 32'd17, 1'b0, 1'b0, 2178, 1'b1, 32'hFFFF_FFFF);
    repeat (600) @(posedge clk);
    #1;
    r2h.start = 1'b1;
    @(posedge clk);
    #1;
    r2h.start = 1'b0;
    wait_done(2300);
    model(64'hFFFF_FFFE_0000_0001, 64'h1234_5678, 1'b1, w, x2);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b0, 2178, 1'b1, w);
    wait_done(2300);
    issue(32'd0, 32'd19, 32'd3, 1'b0, 1'b0, 34, 1'b1, 32'd0);
    wait_done(100);
    issue(32'd3, 32'd5, 32'd17, 1'b1, 1'b0, 2178, 1'b1, 32'hFFFF_FFFF);
    wait_done(2300);
    issue(32'd11, 32'd19, 32'd3, 1'b0, 1'b0, 2178, 1'b1, w1);
    repeat (300) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_m", {h2r.m_msb, h2r.m_lsb}, 64'd0);
    chk("midrst_word", 64'(h2r.rand_word), 64'd0);
    chk("midrst_flags", 64'({h2r.m_valid, h2r.result_valid, h2r.m_valid_upd, h2r.result_valid_upd}), 64'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(32'd11, 32'd19, 32'd3, 1'b0, 1'b0, 2178, 1'b1, w1);
    wait_done(2300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
